// File: rtl/monitor_sweep_scheduler.sv
// Periodic temp/hum/pres acquisition over a shared req/ack bus, with per-sweep
// readback of the classifier code and de-escalation hysteresis on the alert level.
module monitor_sweep_scheduler #(
   parameter int unsigned SAMPLE_PERIOD = 1000,
   parameter int unsigned TIMEOUT       = 64,
   parameter int unsigned HOLD_SWEEPS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       sensor_req,
   output logic [1:0] sensor_sel,
   input  logic       sensor_ack,
   input  logic [7:0] sensor_data,
   output logic [7:0] temp_q,
   output logic [7:0] hum_q,
   output logic [7:0] pres_q,
   input  logic [1:0] alert_in,
   output logic [1:0] alert_level,
   output logic       sweep_done,
   output logic [2:0] sensor_fault,
   output logic       busy
);
   localparam int unsigned PW    = $clog2(SAMPLE_PERIOD + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);
   localparam int unsigned HW_CL = $clog2(HOLD_SWEEPS + 1);
   localparam int unsigned HW    = (HW_CL > 3) ? HW_CL : 3;

   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_SWEEPS - 1);

   typedef enum logic [1:0] {IDLE, ACQ, EVAL} state_t;

   state_t          state, state_d;
   logic [PW-1:0]   period_cnt, period_d;
   logic [TW-1:0]   tmo_cnt, tmo_d;
   logic [HW-1:0]   hyst_cnt, hyst_d;
   logic            req_d;
   logic [1:0]      sel_d;
   logic [7:0]      temp_d, hum_d, pres_d;
   logic [1:0]      level_d;
   logic            done_d;
   logic [2:0]      fault_d;
   logic            busy_d;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         period_cnt   <= '0;
         tmo_cnt      <= '0;
         hyst_cnt     <= '0;
         sensor_req   <= 1'b0;
         sensor_sel   <= 2'd0;
         temp_q       <= 8'd0;
         hum_q        <= 8'd0;
         pres_q       <= 8'd0;
         alert_level  <= 2'd0;
         sweep_done   <= 1'b0;
         sensor_fault <= 3'd0;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         period_cnt   <= period_d;
         tmo_cnt      <= tmo_d;
         hyst_cnt     <= hyst_d;
         sensor_req   <= req_d;
         sensor_sel   <= sel_d;
         temp_q       <= temp_d;
         hum_q        <= hum_d;
         pres_q       <= pres_d;
         alert_level  <= level_d;
         sweep_done   <= done_d;
         sensor_fault <= fault_d;
         busy         <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state;
      period_d = period_cnt;
      tmo_d    = tmo_cnt;
      hyst_d   = hyst_cnt;
      req_d    = sensor_req;
      sel_d    = sensor_sel;
      temp_d   = temp_q;
      hum_d    = hum_q;
      pres_d   = pres_q;
      level_d  = alert_level;
      done_d   = 1'b0;
      fault_d  = sensor_fault;
      busy_d   = busy;

      case (state)
         IDLE: begin
            if (enable) begin
               if (period_cnt == PERIOD_LAST) begin
                  period_d = '0;
                  sel_d    = 2'd0;
                  req_d    = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = ACQ;
               end else begin
                  period_d = period_cnt + PW'(1);
               end
            end
         end
         ACQ: begin
            tmo_d = tmo_cnt + TW'(1);
            // An ack on the expiry cycle still counts as a good sample
            if (sensor_ack || (tmo_cnt == TMO_LAST)) begin
               tmo_d               = '0;
               fault_d[sensor_sel] = ~sensor_ack;
               if (sensor_ack) begin
                  case (sensor_sel)
                     2'd0:    temp_d = sensor_data;
                     2'd1:    hum_d  = sensor_data;
                     default: pres_d = sensor_data;
                  endcase
               end
               if (sensor_sel == 2'd2) begin
                  req_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = EVAL;
               end else begin
                  sel_d = sensor_sel + 2'd1;
               end
            end
         end
         EVAL: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            // Escalate at once; lower only after HOLD_SWEEPS consecutive lower codes
            if (alert_in > alert_level) begin
               level_d = alert_in;
               hyst_d  = '0;
            end else if (alert_in == alert_level) begin
               hyst_d = '0;
            end else if (hyst_cnt == HOLD_LAST) begin
               level_d = alert_in;
               hyst_d  = '0;
            end else begin
               hyst_d = hyst_cnt + HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_monitor_sweep_scheduler.sv
// Bench for monitor_sweep_scheduler: directed sweep table, a mid-sweep reset,
// then randomized sweeps checked against a transaction-level model.
module tb_monitor_sweep_scheduler;
   localparam int unsigned P = 20;
   localparam int unsigned T = 64;
   localparam int unsigned H = 4;
   localparam int BUDGET = 3000;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       sensor_req;
   logic [1:0] sensor_sel;
   logic       sensor_ack;
   logic [7:0] sensor_data;
   logic [7:0] temp_q, hum_q, pres_q;
   logic [1:0] alert_in;
   logic [1:0] alert_level;
   logic       sweep_done;
   logic [2:0] sensor_fault;
   logic       busy;

   always #5 clk = ~clk;

   monitor_sweep_scheduler #(.SAMPLE_PERIOD(P), .TIMEOUT(T), .HOLD_SWEEPS(H)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .sensor_req(sensor_req), .sensor_sel(sensor_sel),
      .sensor_ack(sensor_ack), .sensor_data(sensor_data),
      .temp_q(temp_q), .hum_q(hum_q), .pres_q(pres_q),
      .alert_in(alert_in), .alert_level(alert_level),
      .sweep_done(sweep_done), .sensor_fault(sensor_fault), .busy(busy)
   );

   // lat: cycle of the request in which the sensor acks (0 = never)
   typedef struct packed {
      logic [2:0][6:0] lat;
      logic [2:0][7:0] data;
      logic [1:0]      alert;
      logic [2:0][7:0] exp_q;
      logic [2:0]      exp_fault;
      logic [1:0]      exp_level;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;
   bit stuck  = 1'b0;

   logic [7:0] m_q [3];
   logic [2:0] m_fault;
   logic [1:0] m_level;
   int         hist[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int exp_dur(input int lat);
      return (lat >= 1 && lat <= int'(T)) ? lat : int'(T);
   endfunction

   function automatic vec_t mk(input int l0, input int l1, input int l2,
                               input int d0, input int d1, input int d2, input int al,
                               input int e0, input int e1, input int e2,
                               input int f, input int lv);
      vec_t v;
      v = '0;
      v.lat[0] = 7'(l0);  v.lat[1] = 7'(l1);  v.lat[2] = 7'(l2);
      v.data[0] = 8'(d0); v.data[1] = 8'(d1); v.data[2] = 8'(d2);
      v.alert = 2'(al);
      v.exp_q[0] = 8'(e0); v.exp_q[1] = 8'(e1); v.exp_q[2] = 8'(e2);
      v.exp_fault = 3'(f);
      v.exp_level = 2'(lv);
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      int   r;
      v = '0;
      for (int s = 0; s < 3; s++) begin
         r = int'($urandom_range(0, 9));
         v.lat[s] = (r == 0) ? 7'd0 : (r == 1) ? 7'(T) : (r == 2) ? 7'(T + 1)
                  : 7'($urandom_range(1, 6));
         v.data[s] = 8'($urandom);
      end
      v.alert = 2'($urandom_range(0, 3));
      return v;
   endfunction

   task automatic model_reset();
      m_q[0] = 8'd0; m_q[1] = 8'd0; m_q[2] = 8'd0;
      m_fault = 3'd0;
      m_level = 2'd0;
      hist.delete();
   endtask

   // Sweep outcome from the rules: acked sensors load, others flag; level hysteresis via pending-lower list
   task automatic model_step(input vec_t v);
      for (int s = 0; s < 3; s++) begin
         if (int'(v.lat[s]) >= 1 && int'(v.lat[s]) <= int'(T)) begin
            m_q[s] = v.data[s];
            m_fault[s] = 1'b0;
         end else begin
            m_fault[s] = 1'b1;
         end
      end
      if (v.alert > m_level) begin
         m_level = v.alert;
         hist.delete();
      end else if (v.alert == m_level) begin
         hist.delete();
      end else begin
         hist.push_back(int'(v.alert));
         if (hist.size() == int'(H)) begin
            m_level = v.alert;
            hist.delete();
         end
      end
   endtask

   task automatic do_sweep(input vec_t v, input bit rand_en, input bit use_tbl, input string tag);
      int gap = 0;
      int cyc = 0;
      int cnt[3] = '{0, 0, 0};
      int prev_sel = 0;
      int s;
      bit seen = 1'b0, done = 1'b0, seq_ok = 1'b1, busy_ok = 1'b1, early_done = 1'b0;
      logic [1:0] old_level;
      int e_q[3];
      int e_fault, e_level;
      alert_in  = v.alert;
      old_level = m_level;
      while (!done) begin
         if (sensor_req) begin
            s = int'(sensor_sel);
            if (s == 3 || s < prev_sel || s > prev_sel + 1 || (!seen && s != 0)) seq_ok = 1'b0;
            seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
            if (s < 3) begin
               prev_sel = s;
               cnt[s]++;
               sensor_ack  = (cnt[s] == int'(v.lat[s]));
               sensor_data = sensor_ack ? v.data[s] : 8'($urandom);
            end else begin
               sensor_ack = 1'b0;
            end
            enable = rand_en ? 1'($urandom) : 1'b1;
         end else if (!seen) begin
            if (sweep_done) early_done = 1'b1;
            if (busy) busy_ok = 1'b0;
            enable      = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            sensor_ack  = rand_en ? 1'($urandom) : 1'b0;
            sensor_data = 8'($urandom);
            if (enable) gap++;
         end else begin
            sensor_ack  = rand_en ? 1'($urandom) : 1'b0;
            sensor_data = 8'($urandom);
            if (sweep_done) begin
               done = 1'b1;
               if (!busy) busy_ok = 1'b0;
               chk($sformatf("%s level_during_eval", tag), int'(alert_level), int'(old_level));
            end else begin
               seq_ok = 1'b0;
            end
         end
         if (!done) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > BUDGET) begin
               n_cmp++; n_fail++;
               $display("FAIL %s sweep_timeout: got no sweep_done in %0d cycles, want completion", tag, BUDGET);
               stuck = 1'b1;
               return;
            end
         end
      end
      sensor_ack = 1'b0;
      @(posedge clk); #1;
      model_step(v);
      for (int i = 0; i < 3; i++) e_q[i] = use_tbl ? int'(v.exp_q[i]) : int'(m_q[i]);
      e_fault = use_tbl ? int'(v.exp_fault) : int'(m_fault);
      e_level = use_tbl ? int'(v.exp_level) : int'(m_level);
      chk($sformatf("%s idle_gap", tag), gap, int'(P));
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s req_len%0d", tag, i), cnt[i], exp_dur(int'(v.lat[i])));
      chk($sformatf("%s sel_sequence", tag), int'(seq_ok), 1);
      chk($sformatf("%s busy_track", tag), int'(busy_ok), 1);
      chk($sformatf("%s early_done", tag), int'(early_done), 0);
      chk($sformatf("%s temp_q", tag), int'(temp_q), e_q[0]);
      chk($sformatf("%s hum_q", tag), int'(hum_q), e_q[1]);
      chk($sformatf("%s pres_q", tag), int'(pres_q), e_q[2]);
      chk($sformatf("%s fault", tag), int'(sensor_fault), e_fault);
      chk($sformatf("%s level", tag), int'(alert_level), e_level);
      chk($sformatf("%s done_pulse_end", tag), int'(sweep_done), 0);
      chk($sformatf("%s req_after", tag), int'(sensor_req), 0);
      chk($sformatf("%s busy_after", tag), int'(busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk($sformatf("%s req", tag), int'(sensor_req), 0);
      chk($sformatf("%s sel", tag), int'(sensor_sel), 0);
      chk($sformatf("%s temp", tag), int'(temp_q), 0);
      chk($sformatf("%s hum", tag), int'(hum_q), 0);
      chk($sformatf("%s pres", tag), int'(pres_q), 0);
      chk($sformatf("%s level", tag), int'(alert_level), 0);
      chk($sformatf("%s done", tag), int'(sweep_done), 0);
      chk($sformatf("%s fault", tag), int'(sensor_fault), 0);
      chk($sformatf("%s busy", tag), int'(busy), 0);
   endtask

   // Temp acks at once, hum never acks; reset lands in the 3rd hum request cycle
   task automatic reset_mid_sweep();
      int cyc = 0;
      int c1 = 0;
      alert_in = 2'd0;
      enable   = 1'b1;
      while (cyc < BUDGET) begin
         if (sensor_req && sensor_sel == 2'd1) c1++;
         if (c1 == 3) break;
         sensor_ack  = sensor_req && (sensor_sel == 2'd0);
         sensor_data = 8'h55;
         @(posedge clk); #1;
         cyc++;
      end
      chk("rst_mid reached_hum_request", c1, 3);
      chk("rst_mid temp_loaded", int'(temp_q), 8'h55);
      sensor_ack = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      vec_t tbl[15];
      rst = 1'b1; enable = 1'b0; sensor_ack = 1'b0; sensor_data = 8'd0; alert_in = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      model_reset();
      enable = 1'b1;
      rst = 1'b0;

      //            lat t,h,p   data t,h,p     al  exp t,h,p     flt lvl
      tbl[0]  = mk( 2, 2, 2,   30, 60, 200,   0,  30, 60, 200,  0,  0);
      tbl[1]  = mk( 2, 2, 0,   31, 61,  99,   0,  31, 61, 200,  4,  0);
      tbl[2]  = mk( 1, 3, 2,   32, 62, 210,   3,  32, 62, 210,  0,  3);
      tbl[3]  = mk(64, 1, 1, 127, 63, 211,   1, 127, 63, 211,  0,  3);
      tbl[4]  = mk( 3,65, 2,   33, 64, 212,   1,  33, 63, 212,  2,  3);
      tbl[5]  = mk( 0, 0, 0,    1,  2,   3,   1,  33, 63, 212,  7,  3);
      tbl[6]  = mk( 5, 5, 5,   34, 65, 213,   1,  34, 65, 213,  0,  1);
      tbl[7]  = mk( 1, 1, 1,   35, 66, 214,   2,  35, 66, 214,  0,  2);
      tbl[8]  = mk( 2, 1, 3,   36, 67, 215,   1,  36, 67, 215,  0,  2);
      tbl[9]  = mk( 1, 2, 1,   37, 68, 216,   1,  37, 68, 216,  0,  2);
      tbl[10] = mk( 3, 3, 3,   38, 69, 217,   2,  38, 69, 217,  0,  2);
      tbl[11] = mk( 1, 1, 2,   39, 70, 218,   1,  39, 70, 218,  0,  2);
      tbl[12] = mk( 2, 2, 2,   40, 71, 219,   1,  40, 71, 219,  0,  2);
      tbl[13] = mk( 1, 1, 1,   41, 72, 220,   1,  41, 72, 220,  0,  2);
      tbl[14] = mk( 2, 1, 2,   42, 73, 221,   1,  42, 73, 221,  0,  1);

      for (int i = 0; i < 15; i++) begin
         if (!stuck) do_sweep(tbl[i], 1'b0, 1'b1, $sformatf("vec%0d", i));
      end

      if (!stuck) reset_mid_sweep();

      for (int i = 0; i < 25; i++) begin
         if (!stuck) do_sweep(rnd_vec(), 1'b1, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/monitor_sweep_scheduler.md
Name: monitor_sweep_scheduler

Overview:
Sequences periodic acquisition of the three environmental sensors (temperature, humidity, pressure) over one shared request/acknowledge sensor bus. Holds the latest sample of each sensor in registers that feed the combinational condition classifier. Reads back the classifier's alert code once per sweep and applies de-escalation hysteresis before publishing the system alert level. Sits between the sensor interface and the alert/telemetry path of the node.

Parameters:
SAMPLE_PERIOD, 1000, idle cycles (with enable high) between the end of one sweep and the start of the next; minimum 1
TIMEOUT, 64, cycles a sensor request may stay unacknowledged before it is abandoned; minimum 1
HOLD_SWEEPS, 4, consecutive sweeps with a lower classifier code required before alert_level is lowered; minimum 1

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
enable  input  1  permits new sweeps to start
sensor_req  output  1  request to the shared sensor bus
sensor_sel  output  2  sensor being addressed: 0 = temp, 1 = hum, 2 = pres (3 never driven)
sensor_ack  input  1  sensor response; sensor_data is valid in the same cycle
sensor_data  input  8  sample value
temp_q  output  8  latest temperature sample, to classifier
hum_q  output  8  latest humidity sample, to classifier
pres_q  output  8  latest pressure sample, to classifier
alert_in  input  2  classifier code computed combinationally from temp_q/hum_q/pres_q
alert_level  output  2  hysteresis-filtered alert level
sweep_done  output  1  one-cycle pulse in the cycle alert_level is evaluated
sensor_fault  output  3  per-sensor timeout flag from the most recent attempt; bit index = sensor_sel
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: sensor_req=0, sensor_sel=0, temp_q/hum_q/pres_q=0, alert_level=0, sweep_done=0, sensor_fault=0, busy=0, state=IDLE, period and timeout counters=0, hysteresis counter=0.
- Reset is synchronous and dominates every other condition. Reset mid-sweep drops sensor_req in the following cycle and discards the partial sweep.
- FSM states: IDLE, ACQ, EVAL.
- IDLE:
  - When enable=1, the period counter increments. When enable=0, it holds.
  - When the counter equals SAMPLE_PERIOD-1 with enable=1: clear the counter, set sensor_sel=0, assert sensor_req, go to ACQ.
  - The first sweep after reset therefore starts SAMPLE_PERIOD enabled cycles after reset release.
- ACQ:
  - sensor_req is held high and sensor_sel is stable. The timeout counter increments each cycle.
  - If sensor_ack=1: load sensor_data into the register selected by sensor_sel, clear that sensor's fault bit, clear the timeout counter.
  - Else if the timeout counter equals TIMEOUT-1: set that sensor's fault bit, leave its sample register unchanged, clear the timeout counter.
  - After either event: if sensor_sel<2, increment sensor_sel and keep sensor_req high. The next sensor's request is continuous, with no gap cycle. If sensor_sel==2, drop sensor_req and go to EVAL.
  - An ack arriving in the same cycle as timeout expiry counts as an ack.
  - sensor_ack is ignored outside ACQ.
- EVAL (exactly one cycle):
  - Sample registers are stable, so alert_in is valid.
  - Pulse sweep_done=1 and return to IDLE.
  - Hysteresis:
    - alert_in > alert_level: alert_level <= alert_in, counter <= 0 (escalation is immediate).
    - alert_in == alert_level: counter <= 0.
    - alert_in < alert_level: if counter+1 == HOLD_SWEEPS, then alert_level <= alert_in and counter <= 0; else counter <= counter+1.
  - The hysteresis counter is 3 bits minimum, sized to hold HOLD_SWEEPS.
- enable deasserting mid-sweep does not abort the sweep; it only stops IDLE counting afterwards.
- Latency: a full-ack sweep lasts one IDLE-exit cycle plus (sum of ack latencies) plus one EVAL cycle. alert_level is updated at the clock edge ending EVAL.

Test Plan:
- Sensors ack after 2 cycles with data temp=30, hum=60, pres=200; classifier drives alert_in=0 -> three requests with sel 0,1,2. Registers then read 30/60/200, sweep_done pulses once, alert_level=0, sensor_fault=000, next sweep starts after SAMPLE_PERIOD enabled cycles.
- Pressure sensor never acks, TIMEOUT=64 -> sel=2 request lasts exactly 64 cycles, sensor_fault=100, pres_q keeps its old value. On the next sweep, a pres ack with 210 clears the fault bit and loads pres_q=210.
- alert_in=3 on one sweep, then alert_in=1 for five sweeps, HOLD_SWEEPS=4 -> alert_level=3 immediately after the first EVAL, stays 3 for 3 sweeps, drops to 1 after the 4th.
- De-escalation streak broken: alert_level=2, alert_in sequence 1,1,2,1,1,1,1 -> level stays 2 until the 7th sweep, then 1.
- Ack coincident with the final timeout cycle, data=0x7F -> register loads 0x7F, no fault set.
- rst asserted during the sel=1 request -> next cycle sensor_req=0, all outputs at reset values, no sweep_done. The first new sweep starts SAMPLE_PERIOD enabled cycles after rst release.
